// File: rtl/cache_sets_reconfig_ctrl.sv
`timescale 1ns/1ps
// Owns the unified cache set count: gates core lanes, drains reads, waits for memory idle + settle, commits.
// Optional drain timeout abort: define CACHE_RECFG_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | lanes open (subject to the outstanding limit), cfg accepted
//   S_DRAIN  | lanes gated, waiting for outstanding==0 and mem_idle
//   S_SETTLE | lanes gated, counting down the quiet window
//   S_COMMIT | new set count already driven to the cache
//   S_DONE   | one-cycle cfg_done pulse, cfg_err per outcome
module cache_sets_reconfig_ctrl #(
    parameter int NUM_REQS        = 4,
    parameter int MAX_OUTSTANDING = 64,
    parameter int DEFAULT_SETS    = 64,
    parameter int MAX_SETS        = 1024,
    parameter int SETTLE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES  = 4096,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [11:0]         cfg_sets,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic [11:0]         unified_cache_sets,
    input  logic [NUM_REQS-1:0] core_req_valid_in,
    input  logic [NUM_REQS-1:0] core_req_rw_in,
    output logic [NUM_REQS-1:0] core_req_ready_in,
    output logic [NUM_REQS-1:0] core_req_valid_out,
    input  logic [NUM_REQS-1:0] core_req_ready_out,
    input  logic [NUM_REQS-1:0] core_rsp_fire,
    input  logic                mem_idle,
    output logic                busy,
    output logic [CNT_W-1:0]    outstanding
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_LIMIT  = CNT_W'(MAX_OUTSTANDING - NUM_REQS);
    localparam logic [11:0]      MAX_SETS_L  = 12'(MAX_SETS);
    localparam logic [11:0]      DEF_SETS_L  = 12'(DEFAULT_SETS);

    if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || MAX_SETS > 4095 ||
        MAX_OUTSTANDING < NUM_REQS) begin : g_bad_params
        $error("cache_sets_reconfig_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_SETTLE,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [11:0]        sets_q, sets_d;
    logic [11:0]        req_sets_q, req_sets_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [NUM_REQS-1:0] lane_open;
    logic [CNT_W+1:0]    issue_cnt;
    logic [CNT_W+1:0]    rsp_cnt;
    logic [CNT_W+1:0]    cnt_up;
    logic                reads_ok;
    logic                rsp_underflow;

    function automatic logic sets_legal(input logic [11:0] v);
        return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0) && (v <= MAX_SETS_L);
    endfunction

    // Lane gate and in-flight read accounting
    always_comb begin
        reads_ok      = (outstanding_q <= GATE_LIMIT);
        lane_open     = '0;
        issue_cnt     = '0;
        rsp_cnt       = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            lane_open[i] = reset_n && (state_q == S_IDLE) && (core_req_rw_in[i] || reads_ok);
            issue_cnt    = issue_cnt + (CNT_W+2)'(core_req_valid_in[i] && core_req_ready_out[i]
                                                  && lane_open[i] && !core_req_rw_in[i]);
            rsp_cnt      = rsp_cnt + (CNT_W+2)'(core_rsp_fire[i]);
        end
        cnt_up        = {2'b00, outstanding_q} + issue_cnt;
        rsp_underflow = (rsp_cnt > cnt_up);
        outstanding_d = rsp_underflow ? '0 : CNT_W'(cnt_up - rsp_cnt);
    end

    assign core_req_valid_out = core_req_valid_in & lane_open;
    assign core_req_ready_in  = core_req_ready_out & lane_open;

`ifdef CACHE_RECFG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_q, to_d;
`endif

    always_comb begin
        state_d    = state_q;
        sets_d     = sets_q;
        req_sets_d = req_sets_q;
        settle_d   = settle_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef CACHE_RECFG_TIMEOUT_EN
        to_d       = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    req_sets_d = cfg_sets;
                    if (!sets_legal(cfg_sets)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (cfg_sets == sets_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
`ifdef CACHE_RECFG_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end
                end
            end
            S_DRAIN: begin
                if (outstanding_q == '0 && mem_idle) begin
                    settle_d = SETTLE_LAST;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!mem_idle) begin
                    state_d = S_DRAIN;
                end else if (settle_q == '0) begin
                    // Drive the new count as COMMIT is entered so the cache sees it a cycle before done
                    sets_d  = req_sets_q;
                    state_d = S_COMMIT;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_COMMIT: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef CACHE_RECFG_TIMEOUT_EN
        // Not cleared on SETTLE->DRAIN re-entry, so a flapping mem_idle still times out
        if (state_q == S_DRAIN || state_q == S_SETTLE) begin
            if (to_q == TO_LAST) begin
                state_d = S_DONE;
                sets_d  = sets_q;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            sets_q        <= DEF_SETS_L;
            req_sets_q    <= DEF_SETS_L;
            settle_q      <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sets_q        <= sets_d;
            req_sets_q    <= req_sets_d;
            settle_q      <= settle_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

`ifdef CACHE_RECFG_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!rsp_underflow)
                else $error("cache_sets_reconfig_ctrl: more responses than in-flight reads");
        end
    end
`endif

    assign cfg_ready          = (state_q == S_IDLE);
    assign busy               = (state_q != S_IDLE);
    assign cfg_done           = done_q;
    assign cfg_err            = err_q;
    assign unified_cache_sets = sets_q;
    assign outstanding        = outstanding_q;

endmodule

// File: tb/tb_cache_sets_reconfig_ctrl.sv
`timescale 1ns/1ps
// Directed bench for cache_sets_reconfig_ctrl with hand-computed expectations.
module tb_cache_sets_reconfig_ctrl;

    localparam int NUM_REQS = 4;
    localparam int CNT_W    = 7;

    logic                clk;
    logic                reset_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [11:0]         cfg_sets;
    logic                cfg_done;
    logic                cfg_err;
    logic [11:0]         unified_cache_sets;
    logic [NUM_REQS-1:0] core_req_valid_in;
    logic [NUM_REQS-1:0] core_req_rw_in;
    logic [NUM_REQS-1:0] core_req_ready_in;
    logic [NUM_REQS-1:0] core_req_valid_out;
    logic [NUM_REQS-1:0] core_req_ready_out;
    logic [NUM_REQS-1:0] core_rsp_fire;
    logic                mem_idle;
    logic                busy;
    logic [CNT_W-1:0]    outstanding;

    int nvec = 0;
    int nerr = 0;

    cache_sets_reconfig_ctrl #(
        .NUM_REQS        (4),
        .MAX_OUTSTANDING (64),
        .DEFAULT_SETS    (64),
        .MAX_SETS        (1024),
        .SETTLE_CYCLES   (4),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cfg_sets           (cfg_sets),
        .cfg_done           (cfg_done),
        .cfg_err            (cfg_err),
        .unified_cache_sets (unified_cache_sets),
        .core_req_valid_in  (core_req_valid_in),
        .core_req_rw_in     (core_req_rw_in),
        .core_req_ready_in  (core_req_ready_in),
        .core_req_valid_out (core_req_valid_out),
        .core_req_ready_out (core_req_ready_out),
        .core_rsp_fire      (core_rsp_fire),
        .mem_idle           (mem_idle),
        .busy               (busy),
        .outstanding        (outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
            else begin
                nerr++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    logic [11:0] bad_sets [3];
    logic        saw_done;

    initial begin
        bad_sets[0] = 12'd96;
        bad_sets[1] = 12'd0;
        bad_sets[2] = 12'd2048;

        reset_n            = 1'b0;
        cfg_valid          = 1'b0;
        cfg_sets           = 12'd0;
        core_req_valid_in  = '0;
        core_req_rw_in     = '0;
        core_req_ready_out = '0;
        core_rsp_fire      = '0;
        mem_idle           = 1'b1;

        // Lanes closed while reset held
        #1;
        core_req_valid_in  = 4'hF;
        core_req_ready_out = 4'hF;
        #1;
        chk("rst_valid_out", 32'(core_req_valid_out), 32'd0);
        chk("rst_ready_in", 32'(core_req_ready_in), 32'd0);
        core_req_valid_in  = '0;
        core_req_ready_out = '0;
        tick(2);
        reset_n = 1'b1;
        #1;
        chk("rst_sets", 32'(unified_cache_sets), 32'd64);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_done", 32'(cfg_done), 32'd0);

        // Legal change 64 -> 128 with idle cache: done at C+7, sets at C+6
        tick(1);
        cfg_sets  = 12'd128;
        cfg_valid = 1'b1;
        #1;
        chk("c128_ready_at_accept", 32'(cfg_ready), 32'd1);
        tick(1);
        cfg_valid          = 1'b0;
        core_req_valid_in  = 4'hF;
        core_req_ready_out = 4'hF;
        #1;
        chk("c128_busy", 32'(busy), 32'd1);
        chk("c128_gated_valid", 32'(core_req_valid_out), 32'd0);
        chk("c128_gated_ready", 32'(core_req_ready_in), 32'd0);
        chk("c128_cfg_ready_busy", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b1;
        cfg_sets  = 12'd512;
        tick(1);
        cfg_valid = 1'b0;
        tick(3);
        #1;
        chk("c128_sets_c5", 32'(unified_cache_sets), 32'd64);
        chk("c128_done_c5", 32'(cfg_done), 32'd0);
        chk("c128_no_issue", 32'(outstanding), 32'd0);
        tick(1);
        #1;
        chk("c128_sets_c6", 32'(unified_cache_sets), 32'd128);
        chk("c128_done_c6", 32'(cfg_done), 32'd0);
        tick(1);
        core_req_valid_in  = '0;
        core_req_ready_out = '0;
        #1;
        chk("c128_done_c7", 32'(cfg_done), 32'd1);
        chk("c128_err_c7", 32'(cfg_err), 32'd0);
        tick(1);
        #1;
        chk("c128_done_c8", 32'(cfg_done), 32'd0);
        chk("c128_idle_c8", 32'(busy), 32'd0);
        chk("c128_busy_req_ignored", 32'(unified_cache_sets), 32'd128);

        // Same value: immediate done, no error
        cfg_sets  = 12'd128;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        #1;
        chk("same_done", 32'(cfg_done), 32'd1);
        chk("same_err", 32'(cfg_err), 32'd0);
        tick(1);

        // Illegal values: done+err at accept+1, sets unchanged, no drain
        for (int k = 0; k < 3; k++) begin
            cfg_sets  = bad_sets[k];
            cfg_valid = 1'b1;
            tick(1);
            cfg_valid = 1'b0;
            #1;
            chk("bad_done", 32'(cfg_done), 32'd1);
            chk("bad_err", 32'(cfg_err), 32'd1);
            chk("bad_sets_kept", 32'(unified_cache_sets), 32'd128);
            tick(1);
            #1;
            chk("bad_back_idle", 32'(busy), 32'd0);
        end

        // Three reads in flight, then request 256: waits for responses and mem_idle
        core_req_valid_in  = 4'b0001;
        core_req_ready_out = 4'b0001;
        tick(3);
        core_req_valid_in  = '0;
        core_req_ready_out = '0;
        mem_idle           = 1'b0;
        #1;
        chk("drn_outstanding3", 32'(outstanding), 32'd3);
        cfg_sets  = 12'd256;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        tick(4);
        #1;
        chk("drn_busy", 32'(busy), 32'd1);
        chk("drn_sets_hold", 32'(unified_cache_sets), 32'd128);
        chk("drn_no_done", 32'(cfg_done), 32'd0);
        core_rsp_fire = 4'b0001;
        tick(1);
        #1;
        chk("drn_rsp_flow", 32'(outstanding), 32'd2);
        tick(2);
        core_rsp_fire = '0;
        #1;
        chk("drn_empty", 32'(outstanding), 32'd0);
        tick(2);
        #1;
        chk("drn_wait_mem", 32'(busy), 32'd1);
        chk("drn_wait_done", 32'(cfg_done), 32'd0);
        mem_idle = 1'b1;
        tick(5);
        #1;
        chk("drn_sets256", 32'(unified_cache_sets), 32'd256);
        chk("drn_done_early", 32'(cfg_done), 32'd0);
        tick(1);
        #1;
        chk("drn_done", 32'(cfg_done), 32'd1);
        chk("drn_err", 32'(cfg_err), 32'd0);
        tick(1);

        // Counter: 5 + 2 issues - 1 response = 6
        core_req_valid_in  = 4'hF;
        core_req_ready_out = 4'hF;
        tick(1);
        core_req_valid_in = 4'b0001;
        tick(1);
        #1;
        chk("cnt_five", 32'(outstanding), 32'd5);
        core_req_valid_in = 4'b0011;
        core_rsp_fire     = 4'b0001;
        tick(1);
        core_rsp_fire     = '0;
        core_req_valid_in = '0;
        #1;
        chk("cnt_net_six", 32'(outstanding), 32'd6);
        core_req_valid_in = 4'b0100;
        core_req_rw_in    = 4'b0100;
        tick(1);
        core_req_valid_in = '0;
        core_req_rw_in    = '0;
        #1;
        chk("cnt_write_nocount", 32'(outstanding), 32'd6);

        // Fill to 61: reads gated, writes pass
        core_req_valid_in = 4'hF;
        tick(13);
        core_req_valid_in = 4'b0111;
        tick(1);
        core_req_valid_in = '0;
        #1;
        chk("cnt_61", 32'(outstanding), 32'd61);
        core_req_valid_in = 4'hF;
        core_req_rw_in    = 4'b0101;
        #1;
        chk("lim_valid_out", 32'(core_req_valid_out), 32'd5);
        chk("lim_ready_in", 32'(core_req_ready_in), 32'd5);
        tick(1);
        core_req_valid_in = '0;
        core_req_rw_in    = '0;
        #1;
        chk("lim_writes_only", 32'(outstanding), 32'd61);
        core_rsp_fire = 4'b0001;
        tick(1);
        core_rsp_fire     = '0;
        core_req_valid_in = 4'b0001;
        #1;
        chk("lim_at_60", 32'(outstanding), 32'd60);
        chk("lim_60_open", 32'(core_req_valid_out), 32'd1);
        tick(1);
        core_req_valid_in = '0;
        #1;
        chk("lim_back_61", 32'(outstanding), 32'd61);
        core_rsp_fire = 4'hF;
        tick(15);
        core_rsp_fire = 4'b0001;
        tick(1);
        core_rsp_fire      = '0;
        core_req_ready_out = '0;
        #1;
        chk("cnt_drained", 32'(outstanding), 32'd0);

        // mem_idle drops during SETTLE: back to DRAIN, done at C+10
        cfg_sets  = 12'd512;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        tick(2);
        mem_idle = 1'b0;
        tick(1);
        mem_idle = 1'b1;
        tick(4);
        #1;
        chk("flap_sets_c8", 32'(unified_cache_sets), 32'd256);
        chk("flap_busy_c8", 32'(busy), 32'd1);
        tick(1);
        #1;
        chk("flap_sets_c9", 32'(unified_cache_sets), 32'd512);
        chk("flap_done_c9", 32'(cfg_done), 32'd0);
        tick(1);
        #1;
        chk("flap_done_c10", 32'(cfg_done), 32'd1);
        chk("flap_err_c10", 32'(cfg_err), 32'd0);
        tick(1);

        // Reset during SETTLE with request 1024
        cfg_sets  = 12'd1024;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        tick(2);
        #1;
        chk("rmid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rmid_sets", 32'(unified_cache_sets), 32'd64);
        chk("rmid_idle", 32'(busy), 32'd0);
        tick(2);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (cfg_done) saw_done = 1'b1;
        end
        chk("rmid_no_done", 32'(saw_done), 32'd0);
        chk("rmid_sets_after", 32'(unified_cache_sets), 32'd64);

`ifdef CACHE_RECFG_TIMEOUT_EN
        // Drain timeout: 16 cycles in DRAIN then error, sets unchanged
        mem_idle  = 1'b0;
        cfg_sets  = 12'd128;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        tick(15);
        #1;
        chk("to_not_yet", 32'(cfg_done), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        tick(1);
        #1;
        chk("to_done", 32'(cfg_done), 32'd1);
        chk("to_err", 32'(cfg_err), 32'd1);
        chk("to_sets", 32'(unified_cache_sets), 32'd64);
        tick(1);
        #1;
        chk("to_idle", 32'(busy), 32'd0);
        mem_idle = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cache_sets_reconfig_ctrl.md
Name: cache_sets_reconfig_ctrl

Overview:
Runtime controller that owns the unified_cache_sets configuration of a unified cache instance and changes it safely.
- On a software reconfiguration request it gates new core requests and drains in-flight reads.
- It waits for the memory side to go idle, holds a settle window, then commits the new set count.
- Sits between the core request lanes and the cache wrapper; drives the cache's unified_cache_sets input.

Parameters:
NUM_REQS, 4, number of core request lanes gated/tracked
MAX_OUTSTANDING, 64, max in-flight core reads tracked; CNT_W = CLOG2(MAX_OUTSTANDING+1)
DEFAULT_SETS, 64, unified_cache_sets value after reset
MAX_SETS, 1024, largest legal set count (≤ 4095)
SETTLE_CYCLES, 4, idle cycles held after drain before commit (≥1)
TIMEOUT_CYCLES, 4096, drain timeout (used only with optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous assert, active-low
cfg_valid  in  1  reconfiguration request valid
cfg_ready  out  1  request accepted when cfg_valid&cfg_ready
cfg_sets  in  12  requested set count
cfg_done  out  1  one-cycle completion pulse
cfg_err  out  1  qualifies cfg_done: 1 = rejected/aborted, set count unchanged
unified_cache_sets  out  12  committed set count to the cache
core_req_valid_in  in  NUM_REQS  per-lane request valid from core
core_req_rw_in  in  NUM_REQS  per-lane 1=write (no response), 0=read
core_req_ready_in  out  NUM_REQS  per-lane ready back to core
core_req_valid_out  out  NUM_REQS  per-lane valid to cache
core_req_ready_out  in  NUM_REQS  per-lane ready from cache
core_rsp_fire  in  NUM_REQS  per-lane response handshake (rsp_valid&rsp_ready)
mem_idle  in  1  cache has no pending memory traffic (MSHR/queues empty)
busy  out  1  FSM not in IDLE
outstanding  out  CNT_W  current in-flight read count

Behaviour:
- Reset (reset_n=0, async): state=IDLE, unified_cache_sets=DEFAULT_SETS, outstanding=0, cfg_done=0, cfg_err=0, busy=0, settle counter=0. All core_req_valid_out/ready_in are 0 while reset is asserted.
- Lane gate (combinational), per lane i: open = (state==IDLE) & (rw_in[i] | outstanding ≤ MAX_OUTSTANDING-NUM_REQS).
  - valid_out[i] = valid_in[i] & open.
  - ready_in[i] = ready_out[i] & open.
  - Data/tag pass around this block untouched.
- Counter: next = outstanding + popcount(valid_in&ready_out&open&~rw_in) - popcount(core_rsp_fire).
  - Issue and response in the same cycle net out.
  - If responses exceed count+issues, saturate at 0; simulation assertion fires.
- cfg_ready = (state==IDLE).
- FSM:
  - IDLE: on cfg accept, latch cfg_sets.
    - Illegal value (0, not a power of two, or > MAX_SETS): go to DONE with err=1.
    - Value equal to the current set count: go to DONE with err=0, no drain.
    - Otherwise go to DRAIN.
  - DRAIN: all lanes gated. When outstanding==0 & mem_idle, load settle counter=SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: decrement each cycle. If mem_idle drops, return to DRAIN. At 0, go to COMMIT.
  - COMMIT: unified_cache_sets <= latched value (visible next cycle); go to DONE.
  - DONE: cfg_done=1 for exactly one cycle with cfg_err per outcome; go to IDLE.
- Latency, legal change with an already-idle cache: accept cycle C, cfg_done at C+3+SETTLE_CYCLES. unified_cache_sets is updated one cycle before cfg_done.
- Gated lanes hold valid_in; a request is never accepted while gated. Responses keep flowing during DRAIN/SETTLE.
- cfg_valid while busy: not accepted (cfg_ready=0); no queueing.
- Reset mid-reconfiguration: returns to IDLE with DEFAULT_SETS; no cfg_done is issued.

Optional Feature:
CACHE_RECFG_TIMEOUT_EN
- Defined: a counter clears on entry to DRAIN and increments during DRAIN/SETTLE. On reaching TIMEOUT_CYCLES, go to DONE with cfg_err=1; unified_cache_sets is unchanged and lanes reopen.
- Undefined: no counter; DRAIN waits indefinitely.

Test Plan:
- Reset then idle -> unified_cache_sets=64, busy=0, outstanding=0, cfg_ready=1.
- cfg_sets=128 with cache idle, SETTLE_CYCLES=4 -> unified_cache_sets=128 one cycle before cfg_done; cfg_done at accept+7 with cfg_err=0; lanes gated throughout.
- Issue 3 reads on lane 0 with no responses, then request cfg_sets=256 -> stays in DRAIN; after the 3rd core_rsp_fire and mem_idle=1, completes with sets=256, err=0.
- cfg_sets=96, 0, and 2048 -> each gives cfg_done/cfg_err=1 at accept+1, sets unchanged, no gating.
- Same cycle: 2 read issues plus 1 response with outstanding=5 -> outstanding=6. Outstanding=61 with NUM_REQS=4 -> reads gated, writes pass.
- With CACHE_RECFG_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_idle held 0 -> cfg_err=1 pulse after 16 cycles in DRAIN, sets unchanged. Separately, reset_n low during SETTLE -> sets=64, no cfg_done.
